// File: rtl/logic_reg_responder_pkg.sv
// Shared constants, FSM encoding and address decode for the logic-bus responder.
// Anything that talks to the 12/16-bit logic bus can reuse this package.
package logic_reg_responder_pkg;

  localparam int ADR_W = 12;
  localparam int DAT_W = 16;

  localparam logic [ADR_W-1:0] ADR_STATUS = 12'h0FE;
  localparam logic [ADR_W-1:0] ADR_ID     = 12'h0FF;
  localparam logic [DAT_W-1:0] DEAD_WORD  = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_ACK,
    ST_REL
  } state_t;

  typedef enum logic [2:0] {
    RG_LOCAL,
    RG_STATUS,
    RG_ID,
    RG_EXT,
    RG_UNMAPPED
  } region_t;

  // Local registers win over every other window when the ranges overlap.
  function automatic region_t decode_adr(input logic [ADR_W-1:0] adr,
                                         input int               n_regs,
                                         input logic [ADR_W-1:0] ext_base);
    if (int'(adr) < n_regs) return RG_LOCAL;
    if (adr == ADR_STATUS)  return RG_STATUS;
    if (adr == ADR_ID)      return RG_ID;
    if (adr >= ext_base)    return RG_EXT;
    return RG_UNMAPPED;
  endfunction

endpackage

// File: rtl/logic_reg_responder_ext_timeout.sv
// Loadable down-counter with an expiry flag; shared by the bus bridges that
// need to give up on a silent downstream port.
module logic_ext_timeout
  import logic_reg_responder_pkg::*;
#(
  parameter int W = DAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/logic_reg_responder.sv
// Terminates the UART command processor's logic bus: local R/W registers,
// status and ID words, and a timed-out forwarding window for high addresses.
module logic_reg_responder
  import logic_reg_responder_pkg::*;
#(
  parameter int               N_REGS      = 16,
  parameter logic [DAT_W-1:0] REG_RST     = 16'h0000,
  parameter logic [DAT_W-1:0] FW_ID       = 16'h0001,
  parameter logic [ADR_W-1:0] EXT_BASE    = 12'h100,
  parameter int               EXT_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADR_W-1:0]        i_logic_adr,
  input  logic [DAT_W-1:0]        i_logic_wr_data,
  input  logic                    i_logic_wr_req,
  input  logic                    i_logic_rd_req,
  output logic                    o_logic_ack,
  output logic [DAT_W-1:0]        o_logic_rd_data,
  input  logic [DAT_W-1:0]        i_stat_in,
  output logic [DAT_W*N_REGS-1:0] o_reg_q,
  output logic [N_REGS-1:0]       o_wr_strobe,
  output logic [ADR_W-1:0]        o_ext_adr,
  output logic [DAT_W-1:0]        o_ext_wr_data,
  output logic                    o_ext_wr_req,
  output logic                    o_ext_rd_req,
  input  logic                    i_ext_ack,
  input  logic [DAT_W-1:0]        i_ext_rd_data,
  output logic [DAT_W-1:0]        o_err_cnt
);

  localparam int               IDX_W    = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  // Loading TIMEOUT-1 keeps the downstream request up for exactly EXT_TIMEOUT cycles.
  localparam logic [DAT_W-1:0] TMO_LOAD = DAT_W'(EXT_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [DAT_W-1:0] r_regs [N_REGS];
  logic             r_is_wr;

  logic             w_req;
  logic             w_is_wr;
  logic             w_accept;
  logic             w_in_ext;
  logic             w_expired;
  logic             w_ext_done;
  logic             w_timeout;
  logic             w_err_inc;
  region_t          w_region;
  logic [IDX_W-1:0] w_idx;

  assign w_req      = i_logic_wr_req | i_logic_rd_req;
  assign w_is_wr    = i_logic_wr_req;
  assign w_region   = decode_adr(i_logic_adr, N_REGS, EXT_BASE);
  assign w_idx      = i_logic_adr[IDX_W-1:0];
  assign w_accept   = (r_state == ST_IDLE) && w_req;
  assign w_in_ext   = (r_state == ST_EXT);
  assign w_ext_done = w_in_ext && i_ext_ack;
  assign w_timeout  = w_in_ext && !i_ext_ack && w_expired;
  assign w_err_inc  = (w_accept && (w_region == RG_UNMAPPED)) || w_timeout;

  logic_ext_timeout #(.W(DAT_W)) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (TMO_LOAD),
    .i_en       (w_in_ext),
    .o_expired  (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // REL holds off re-acceptance until the master has released both requests.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_next = (w_region == RG_EXT) ? ST_EXT : ST_ACK;
      ST_EXT:  if (i_ext_ack || w_expired) w_next = ST_ACK;
      ST_ACK:  w_next = ST_REL;
      ST_REL:  if (!w_req) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_logic_ack = (r_state == ST_ACK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_wr         <= 1'b0;
      o_logic_rd_data <= '0;
      o_ext_adr       <= '0;
      o_ext_wr_data   <= '0;
      o_ext_wr_req    <= 1'b0;
      o_ext_rd_req    <= 1'b0;
      o_err_cnt       <= '0;
    end else begin
      if (w_accept) begin
        r_is_wr <= w_is_wr;
        if (!w_is_wr) begin
          case (w_region)
            RG_LOCAL:    o_logic_rd_data <= r_regs[w_idx];
            RG_STATUS:   o_logic_rd_data <= i_stat_in;
            RG_ID:       o_logic_rd_data <= FW_ID;
            RG_UNMAPPED: o_logic_rd_data <= DEAD_WORD;
            default:     ;
          endcase
        end
        if (w_region == RG_EXT) begin
          o_ext_adr     <= i_logic_adr - EXT_BASE;
          o_ext_wr_data <= i_logic_wr_data;
          o_ext_wr_req  <= w_is_wr;
          o_ext_rd_req  <= !w_is_wr;
        end
      end
      if (w_ext_done) begin
        o_ext_wr_req <= 1'b0;
        o_ext_rd_req <= 1'b0;
        if (!r_is_wr) o_logic_rd_data <= i_ext_rd_data;
      end
      if (w_timeout) begin
        o_ext_wr_req    <= 1'b0;
        o_ext_rd_req    <= 1'b0;
        o_logic_rd_data <= DEAD_WORD;
      end
      if (w_err_inc && (o_err_cnt != 16'hFFFF)) o_err_cnt <= o_err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_wr_strobe <= '0;
      for (int k = 0; k < N_REGS; k++) r_regs[k] <= REG_RST;
    end else begin
      o_wr_strobe <= '0;
      for (int k = 0; k < N_REGS; k++) begin
        if (w_accept && w_is_wr && (w_region == RG_LOCAL) && (int'(w_idx) == k)) begin
          r_regs[k]      <= i_logic_wr_data;
          o_wr_strobe[k] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_reg_q = '0;
    for (int k = 0; k < N_REGS; k++) o_reg_q[DAT_W*k +: DAT_W] = r_regs[k];
  end

endmodule
